rs_erasure_locator_scan: RTL and testbench
==========================================

// Module: rs_erasure_locator_scan
// PURPOSE
//  Read-side companion of the 1-bit x 256 decoder erasure-flag RAM. After the
//  receive path has written one codeword's flags, this block scans the RAM,
//  converts every set flag into a symbol position and streams the positions
//  to the erasure-locator polynomial builder. It also reports the erasure
//  count and an overflow flag when erasures exceed the correction capability.
// PARAMETERS
//  N          255  codeword length in symbols; scan covers addresses 0..N-1
//  MAX_ERAS   16   max correctable erasures (N-K); positions beyond are dropped
//  ADDR_W     8    flag RAM address width and position width
//  FIFO_DEPTH 4    output position FIFO depth (power of 2, >=2)
// PORTS
//  clock        in   1       system clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse: begin scan of current codeword
//  rdaddress    out  ADDR_W  flag RAM read address
//  rden         out  1       flag RAM read enable
//  q            in   1       flag RAM data, valid 1 cycle after rden
//  pos_valid    out  1       pos_data valid
//  pos_ready    in   1       consumer accepts pos_data when pos_valid&&pos_ready
//  pos_data     out  ADDR_W  erasure position = N-1-address (alpha exponent)
//  eras_count   out  ADDR_W  erasures found, saturates at N; valid when done=1
//  overflow     out  1       eras_count > MAX_ERAS; valid when done=1
//  busy         out  1       scan in progress (SCAN or DRAIN)
//  done         out  1       1-cycle pulse: scan complete, FIFO drained
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
//  - States: IDLE -> SCAN on start; SCAN -> DRAIN after read of address N-1
//    issued; DRAIN -> DONE when last read returned and FIFO empty;
//    DONE -> IDLE next cycle (done=1 for exactly that cycle).
//  - start outside IDLE ignored. Start in IDLE clears eras_count/overflow.
//  - SCAN: rden=1, rdaddress increments 0..N-1, one per cycle, unless stalled.
//  - Read pipeline: 1-cycle; a registered tag (valid, address) follows each
//    rden so q is paired with its own address.
//  - On q=1 with tag valid: eras_count++ (saturating at N). If pre-increment
//    count < MAX_ERAS, push N-1-addr into FIFO; else drop and set overflow.
//  - Stall: rden deasserts (address held) when FIFO free slots <= in-flight
//    reads; guarantees no push into a full FIFO, no flag lost or duplicated.
//  - FIFO push and pop in same cycle allowed when full or empty+bypass-free
//    (no combinational path q->pos_valid; pos_data registered from FIFO head).
//  - Output order: strictly increasing address, i.e. decreasing pos_data.
//  - pos_valid held with stable pos_data until accepted (valid/ready rule).
//  - Zero erasures: done after N reads + drain, pos_valid never asserted.
//  - reset_n asserted mid-scan: immediate abort, FIFO flushed, no done pulse.
// STRUCTURE
//  - Shared package rs_pkg: RS_N=255, RS_K=239, SYM_W=8, state enum
//    {IDLE,SCAN,DRAIN,DONE}.
//  - One sub-module: rs_erasure_pos_fifo (sync FIFO, FIFO_DEPTH x ADDR_W,
//    push/pop/full/empty/level, async active-low reset).
//  - Top: FSM, address counter, read tag pipe, erasure counter, stall logic.
// TESTING
//  1 Flags at addr 3,10,254, pos_ready=1 -> pos_data 251,244,0 in order;
//    done with eras_count=3, overflow=0; scan takes N+~3 cycles.
//  2 No flags set -> no pos_valid; done pulse; eras_count=0, overflow=0.
//  3 20 flags at addr 0..19 -> 16 positions 254..239 emitted; eras_count=20,
//    overflow=1.
//  4 Flags at 5,6,7,8,9,10 with pos_ready=0 for 50 cycles then 1 -> rden
//    stalls, all 6 positions 249..244 delivered, none lost or duplicated.
//  5 start re-pulsed during SCAN -> ignored; single done, results unchanged.
//  6 reset_n low at address 100 mid-scan -> outputs 0 next edge, no done;
//    new start afterwards gives correct full result.

Source files
------------

// File: rtl/rs_erasure_locator_scan_pkg.sv
// Shared Reed-Solomon constants and scan state encoding for the erasure
// locator scan block.
package rs_erasure_locator_scan_pkg;

    localparam int RS_N        = 255;
    localparam int RS_K        = 239;
    localparam int SYM_W       = 8;
    localparam int RS_MAX_ERAS = RS_N - RS_K;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_e;

endpackage

// File: rtl/rs_erasure_locator_scan_if.sv
// Erasure position stream (valid/ready) from the scan block to the
// erasure-locator polynomial builder.
interface rs_erasure_locator_scan_if #(
    parameter int ADDR_W = 8
);
    logic              pos_valid;
    logic              pos_ready;
    logic [ADDR_W-1:0] pos_data;

    modport master (output pos_valid, output pos_data, input pos_ready);
    modport slave  (input pos_valid, input pos_data, output pos_ready);
endinterface

// File: rtl/rs_erasure_locator_scan_pos_fifo.sv
// Small synchronous position FIFO; the head entry is read straight from a
// register so the consumer sees no combinational path from the RAM data.
module rs_erasure_locator_scan_pos_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rs_erasure_locator_scan.sv
// Scans the 1-bit erasure flag RAM after each codeword and streams the
// erasure positions (alpha exponents) with count and overflow status.
module rs_erasure_locator_scan
    import rs_erasure_locator_scan_pkg::*;
#(
    parameter int N          = RS_N,
    parameter int MAX_ERAS   = RS_MAX_ERAS,
    parameter int ADDR_W     = SYM_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    output logic [ADDR_W-1:0]          rdaddress,
    output logic                       rden,
    input  logic                       q,
    rs_erasure_locator_scan_if.master  pos_if,
    output logic [ADDR_W-1:0]          eras_count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    scan_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rden_q;
    logic              tag_vld_q;
    logic [ADDR_W-1:0] tag_addr_q;
    logic [ADDR_W-1:0] count_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;

    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;
    logic [LVL_W-1:0]  free_slots;
    logic [LVL_W-1:0]  in_flight;
    logic              can_issue;
    logic              hit;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_data;

    // A new read is only issued if every read already outstanding could still
    // land in the FIFO, so a flag is never dropped for lack of space.
    always_comb begin
        in_flight  = LVL_W'(tag_vld_q) + LVL_W'(rden_q);
        free_slots = LVL_W'(FIFO_DEPTH) - fifo_level;
        can_issue  = (free_slots > in_flight);
        hit        = tag_vld_q && q;
        pop        = !fifo_empty && pos_if.pos_ready;
        push       = hit && (count_q < ADDR_W'(MAX_ERAS)) && (!fifo_full || pop);
        push_data  = ADDR_W'(N - 1) - tag_addr_q;
    end

    rs_erasure_locator_scan_pos_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W)
    ) u_pos_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rden_q     <= 1'b0;
            tag_vld_q  <= 1'b0;
            tag_addr_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            tag_vld_q  <= rden_q;
            tag_addr_q <= addr_q;

            if (hit) begin
                if (count_q != ADDR_W'(N)) begin
                    count_q <= count_q + ADDR_W'(1);
                end
                if (count_q >= ADDR_W'(MAX_ERAS)) begin
                    ovf_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        addr_q  <= '0;
                        rden_q  <= can_issue;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (rden_q) begin
                        if (addr_q == ADDR_W'(N - 1)) begin
                            rden_q  <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            rden_q <= can_issue;
                        end
                    end else begin
                        rden_q <= can_issue;
                    end
                end
                DRAIN: begin
                    if (!tag_vld_q && fifo_empty) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdaddress        = addr_q;
    assign rden             = rden_q;
    assign pos_if.pos_valid = !fifo_empty;
    assign pos_if.pos_data  = fifo_head;
    assign eras_count       = count_q;
    assign overflow         = ovf_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_rs_erasure_locator_scan.sv
// Directed and randomized scans of a modelled flag RAM, checked against a
// list-based model of which positions, count and overflow must result.
module tb_rs_erasure_locator_scan;

    localparam int N  = 255;
    localparam int ME = 16;
    localparam int AW = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic          q       = 1'b0;
    logic [AW-1:0] rdaddress;
    logic          rden;
    logic [AW-1:0] eras_count;
    logic          overflow;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    bit            flags [256];
    bit            hold_low  = 1'b0;
    bit            rnd_ready = 1'b0;
    logic [AW-1:0] rx_q [$];
    bit            pend = 1'b0;
    logic [AW-1:0] pend_data = '0;

    rs_erasure_locator_scan_if #(.ADDR_W(AW)) pos_if ();

    rs_erasure_locator_scan dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .rdaddress  (rdaddress),
        .rden       (rden),
        .q          (q),
        .pos_if     (pos_if),
        .eras_count (eras_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Flag RAM: one-cycle read latency, garbage on the data line when not read.
    always @(posedge clock) begin
        q <= rden ? flags[rdaddress] : 1'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Consumer: drive ready, collect accepted positions, check valid/ready holding.
    always @(negedge clock) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else if (pend) begin
            chk("hold_valid", 32'(pos_if.pos_valid), 1);
            chk("hold_data", 32'(pos_if.pos_data), 32'(pend_data));
        end
        pos_if.pos_ready = hold_low ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
        if (reset_n && pos_if.pos_valid && pos_if.pos_ready) begin
            rx_q.push_back(pos_if.pos_data);
        end
        pend      = reset_n && pos_if.pos_valid && !pos_if.pos_ready;
        pend_data = pos_if.pos_data;
    end

    task automatic clear_flags();
        for (int a = 0; a < 256; a++) flags[a] = 1'b0;
    endtask

    task automatic random_flags(input int pct);
        for (int a = 0; a < 256; a++) flags[a] = (($urandom % 100) < pct);
    endtask

    task automatic run_scan(input string tag, input int hold_cyc, input int restart_at,
                            input bit check_lat);
        int            exp_n;
        logic [AW-1:0] exp_q [$];
        int            cyc;
        bit            got;
        int            extra_done;
        exp_n = 0;
        for (int a = 0; a < N; a++) begin
            if (flags[a]) begin
                if (exp_n < ME) exp_q.push_back(AW'(N - 1 - a));
                exp_n++;
            end
        end
        rx_q.delete();
        hold_low = (hold_cyc > 0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            if (cyc == hold_cyc) hold_low = 1'b0;
            if (hold_cyc > 0 && cyc == 40) chk({tag, "_stall_rden"}, 32'(rden), 0);
            start = (cyc == restart_at);
            if (done) got = 1'b1;
        end
        start    = 1'b0;
        hold_low = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 1);
        if (check_lat) chk({tag, "_latency"}, 32'(cyc >= N && cyc <= N + 4), 1);
        chk({tag, "_count"}, 32'(eras_count), 32'((exp_n > N) ? N : exp_n));
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_n > ME));
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_npos"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_pos"}, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        extra_done = 0;
        repeat (4) begin
            @(negedge clock);
            if (done) extra_done++;
        end
        chk({tag, "_single_done"}, 32'(extra_done), 0);
        chk({tag, "_count_hold"}, 32'(eras_count), 32'((exp_n > N) ? N : exp_n));
        chk({tag, "_no_valid_after"}, 32'(pos_if.pos_valid), 0);
    endtask

    initial begin
        int  cyc;
        bit  reached;
        pos_if.pos_ready = 1'b1;
        clear_flags();

        #2;
        chk("rst_rden", 32'(rden), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(pos_if.pos_valid), 0);
        chk("rst_count", 32'(eras_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        clear_flags();
        flags[3] = 1'b1; flags[10] = 1'b1; flags[254] = 1'b1;
        run_scan("three", 0, 0, 1'b1);

        clear_flags();
        run_scan("zero", 0, 0, 1'b1);

        clear_flags();
        for (int a = 0; a < 20; a++) flags[a] = 1'b1;
        run_scan("twenty", 0, 0, 1'b1);

        clear_flags();
        for (int a = 5; a <= 10; a++) flags[a] = 1'b1;
        run_scan("stall", 50, 0, 1'b0);

        clear_flags();
        flags[3] = 1'b1; flags[10] = 1'b1; flags[254] = 1'b1;
        run_scan("restart", 0, 100, 1'b1);

        random_flags(4);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        reached = 1'b0;
        while (!reached && cyc < 400) begin
            if (rden && rdaddress == AW'(100)) reached = 1'b1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("abort_reached", 32'(reached), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_rden", 32'(rden), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(pos_if.pos_valid), 0);
        chk("abort_count", 32'(eras_count), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
        end
        run_scan("rerun", 0, 0, 1'b1);

        rnd_ready = 1'b1;
        random_flags(2);
        run_scan("rand_a", 0, 0, 1'b0);
        random_flags(6);
        run_scan("rand_b", 0, 0, 1'b0);
        random_flags(12);
        run_scan("rand_c", 0, 0, 1'b0);
        random_flags(50);
        run_scan("rand_d", 0, 0, 1'b0);
        rnd_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
